sram_port_arb: RTL and testbench
================================

# sram_port_arb

Parametrised N-channel arbiter that merges several sram-like master ports (instruction fetch, data access, future extra requesters) onto one shared sram-like slave port with one-cycle read latency. It sits between the core's `*_sram_*` ports and a single memory or bridge. It replaces fixed point-to-point wiring with round-robin arbitration, per-channel grant/stall, and per-channel read-return tagging.

## Interface
Parameters:
- `NUM_CH`, default 2: number of master channels; 1..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; a multiple of 8. Write-enable width is `DATA_W/8`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ch_en`  in  NUM_CH  per-channel request.
- `ch_wen`  in  NUM_CH*DATA_W/8  per-channel byte write enables; all zero means read.
- `ch_addr`  in  NUM_CH*ADDR_W  per-channel address.
- `ch_wdata`  in  NUM_CH*DATA_W  per-channel write data.
- `ch_gnt`  out  NUM_CH  one-hot-or-zero grant; same cycle as the request.
- `ch_stallreq`  out  NUM_CH  `ch_en & ~ch_gnt`; feeds the pipeline stall controller.
- `ch_rvalid`  out  NUM_CH  read data for this channel is on `ch_rdata`.
- `ch_rdata`  out  NUM_CH*DATA_W  per-channel read data.
- `sram_en`  out  1  slave request.
- `sram_wen`  out  DATA_W/8  slave byte write enables.
- `sram_addr`  out  ADDR_W  slave address.
- `sram_wdata`  out  DATA_W  slave write data.
- `sram_rdata`  in  DATA_W  slave read data, valid one cycle after `sram_en` with zero `sram_wen`.

Channel k occupies slice `[k*W +: W]` of each flattened bus.

## Operation
- State: round-robin pointer `ptr` (clog2(NUM_CH) bits, min 1), response register `resp_ch` (one-hot NUM_CH), and optional hold registers.
- Arbitration is combinational. Among asserted `ch_en`, grant the first channel found searching `ptr, ptr+1, …` modulo NUM_CH. Exactly one grant when any request is present, otherwise none.
- The granted channel's `wen/addr/wdata` drive the slave. `sram_en = |ch_gnt`. With no grant, `sram_wen/addr/wdata` are 0.
- Pointer update on a grant to channel g: `ptr <= (g == NUM_CH-1) ? 0 : g+1`. With no grant, `ptr` holds.
- Read grant (granted `wen == 0`): `resp_ch <= ch_gnt`. Write grant or no grant: `resp_ch <= 0`.
- `ch_rvalid = resp_ch`. Writes never produce `rvalid`.
- A channel with an ungranted request keeps `ch_en/wen/addr/wdata` stable until granted; the arbiter does not check this.
- NUM_CH = 1: the channel is always granted; `ptr` stays 0.
- Reset (`rst` high in a cycle): `ch_gnt = 0`, `sram_en = 0`, `ch_stallreq = ch_en`. On that edge, `ptr <= 0` and `resp_ch <= 0`. A read granted in the cycle before reset has its response dropped, with no `rvalid`.

## Timing
- Grant latency: 0 cycles (combinational from `ch_en` and `ptr`).
- Read latency: `ch_rvalid[k]` is high exactly 1 cycle after the grant cycle, for 1 cycle.
- Back-to-back: one grant per cycle. A read response and a new grant may coincide.
- Output values during and after reset: `ch_gnt` 0, `ch_rvalid` 0, `sram_en` 0, `ch_rdata` 0 (see Configuration).
- Fairness: a continuously requesting channel waits at most NUM_CH-1 cycles.

## Configuration
- `SRAM_ARB_RDATA_HOLD_EN` defined:
  - Each channel has a DATA_W hold register, loaded from `sram_rdata` in its `rvalid` cycle.
  - `ch_rdata[k]` shows `sram_rdata` during `rvalid`, and the held value afterwards until the next read response.
  - Hold registers reset to 0.
- Not defined:
  - No hold registers.
  - Every `ch_rdata` slice is `sram_rdata` gated by that channel's `rvalid`; 0 when `rvalid` is low.

## Test plan
- Reset: `rst` = 1 for 2 cycles with `ch_en` = 2'b11 -> `ch_gnt` = 0, `sram_en` = 0, `ch_stallreq` = 2'b11, `ch_rvalid` = 0; then release -> ch0 granted first (ptr = 0).
- Contention: NUM_CH = 2, both channels read continuously (addr 0x100 and 0x200) for 4 cycles -> grants alternate ch0, ch1, ch0, ch1; `sram_addr` alternates 0x100/0x200; `rvalid` follows one cycle later on the alternating channel, with `ch_rdata` equal to the stub's data.
- Write: ch1 writes `wen` 4'b0011, addr 0x40, wdata 0xDEADBEEF, alone -> `sram_wen` = 4'b0011, `sram_wdata` = 0xDEADBEEF the same cycle; no `ch_rvalid` the next cycle; ptr -> 0.
- Wrap and fairness: NUM_CH = 4, ptr = 3, requests 4'b1001 -> ch3 granted, ptr -> 0; next cycle, same requests -> ch0 granted.
- Reset mid-read: grant a ch0 read, assert `rst` the next cycle -> `ch_rvalid` stays 0 and ptr = 0 after reset.
- Hold (with macro): ch0 reads 0x12345678, then is idle 3 cycles -> `ch_rdata[0]` stays 0x12345678; without the macro -> 0 after the `rvalid` cycle.

Source files
------------

// File: rtl/sram_port_arb_if.sv
// Bundle of the per-channel sram-like master buses and the shared slave bus around sram_port_arb.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface sram_port_arb_if #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH*BE_W-1:0]   ch_wen;
    logic [NUM_CH*ADDR_W-1:0] ch_addr;
    logic [NUM_CH*DATA_W-1:0] ch_wdata;
    logic [NUM_CH-1:0]        ch_gnt;
    logic [NUM_CH-1:0]        ch_stallreq;
    logic [NUM_CH-1:0]        ch_rvalid;
    logic [NUM_CH*DATA_W-1:0] ch_rdata;
    logic                     sram_en;
    logic [BE_W-1:0]          sram_wen;
    logic [ADDR_W-1:0]        sram_addr;
    logic [DATA_W-1:0]        sram_wdata;
    logic [DATA_W-1:0]        sram_rdata;

    modport slave (
        input  ch_en, ch_wen, ch_addr, ch_wdata, sram_rdata,
        output ch_gnt, ch_stallreq, ch_rvalid, ch_rdata,
        output sram_en, sram_wen, sram_addr, sram_wdata
    );

    modport master (
        output ch_en, ch_wen, ch_addr, ch_wdata, sram_rdata,
        input  ch_gnt, ch_stallreq, ch_rvalid, ch_rdata,
        input  sram_en, sram_wen, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arb.sv
// Round-robin merge of NUM_CH sram-like masters onto one slave: grant in 0 cycles, read return after 1; losers stall.
// Optional SRAM_ARB_RDATA_HOLD_EN keeps each channel's last read data on ch_rdata after its rvalid cycle.
module sram_port_arb #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic           clk,
    input logic           rst,
    sram_port_arb_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] resp_q, resp_d;
    logic [NUM_CH-1:0] gnt;
    logic              gnt_any;
    logic [BE_W-1:0]   mux_wen;
    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;
    logic [NUM_CH-1:0] rvalid;

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= NUM_CH) ? s - NUM_CH : s;
    endfunction

    // Search order starts at ptr_q; the first requester met wins.
    always_comb begin : arb
        gnt     = '0;
        gnt_any = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!rst && !gnt_any && bus.ch_en[k] && (wrap_idx(int'(ptr_q), i) == k)) begin
                    gnt[k]  = 1'b1;
                    gnt_any = 1'b1;
                end
            end
        end
    end

    always_comb begin : slave_mux
        mux_wen   = '0;
        mux_addr  = '0;
        mux_wdata = '0;
        ptr_d     = ptr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt[k]) begin
                mux_wen   = bus.ch_wen[k*BE_W +: BE_W];
                mux_addr  = bus.ch_addr[k*ADDR_W +: ADDR_W];
                mux_wdata = bus.ch_wdata[k*DATA_W +: DATA_W];
                ptr_d     = (k == NUM_CH - 1) ? '0 : PTR_W'(k + 1);
            end
        end
        resp_d = (gnt_any && (mux_wen == '0)) ? gnt : '0;
    end

    // A read granted just before reset must not surface during the reset cycle.
    assign rvalid = rst ? '0 : resp_q;

    assign bus.ch_gnt      = gnt;
    assign bus.ch_stallreq = bus.ch_en & ~gnt;
    assign bus.ch_rvalid   = rvalid;
    assign bus.sram_en     = gnt_any;
    assign bus.sram_wen    = mux_wen;
    assign bus.sram_addr   = mux_addr;
    assign bus.sram_wdata  = mux_wdata;

`ifdef SRAM_ARB_RDATA_HOLD_EN
    logic [NUM_CH-1:0][DATA_W-1:0] hold_q, hold_d;

    always_comb begin : rdata_hold
        hold_d       = hold_q;
        bus.ch_rdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rvalid[k]) begin
                hold_d[k] = bus.sram_rdata;
            end
            bus.ch_rdata[k*DATA_W +: DATA_W] = rvalid[k] ? bus.sram_rdata
                                                         : (rst ? '0 : hold_q[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    always_comb begin : rdata_gate
        bus.ch_rdata = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (rvalid[k]) begin
                bus.ch_rdata[k*DATA_W +: DATA_W] = bus.sram_rdata;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= '0;
            resp_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            resp_q <= resp_d;
        end
    end
endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: 2- and 4-channel instances driven in lockstep against a round-robin reference model.
module tb_sram_port_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_port_arb_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) b2 ();
    sram_port_arb_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) b4 ();

    sram_port_arb #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) u_arb2 (.clk(clk), .rst(rst), .bus(b2));
    sram_port_arb #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) u_arb4 (.clk(clk), .rst(rst), .bus(b4));

`ifdef SRAM_ARB_RDATA_HOLD_EN
    localparam logic [31:0] HOLD_EXP = 32'h1234_5678;
`else
    localparam logic [31:0] HOLD_EXP = 32'h0;
`endif

    int n_err = 0;
    int n_chk = 0;

    // stimulus per instance (index 0: 2 channels, 1: 4 channels)
    logic [3:0]  en    [2];
    logic [3:0]  wen   [2][4];
    logic [31:0] addr  [2][4];
    logic [31:0] wdata [2][4];
    bit          locked[2][4];

    // reference model state
    int          ptr    [2];
    int          resp   [2];
    logic [31:0] rd_addr[2];
    logic [31:0] rdat   [2];
    logic [31:0] hold   [2][4];

    // last observed values, for directed scenario checks
    logic [3:0]   o_gnt  [2];
    logic [3:0]   o_st   [2];
    logic [3:0]   o_rv   [2];
    logic [3:0]   o_wen  [2];
    logic [31:0]  o_addr [2];
    logic [31:0]  o_wdata[2];
    logic [127:0] o_rdata[2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stub(input logic [31:0] a);
        if (a == 32'h300) return 32'h1234_5678;
        return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
    endfunction

    task automatic drive_bus();
        b2.ch_en      = en[0][1:0];
        b2.sram_rdata = rdat[0];
        for (int k = 0; k < 2; k++) begin
            b2.ch_wen[k*4 +: 4]     = wen[0][k];
            b2.ch_addr[k*32 +: 32]  = addr[0][k];
            b2.ch_wdata[k*32 +: 32] = wdata[0][k];
        end
        b4.ch_en      = en[1];
        b4.sram_rdata = rdat[1];
        for (int k = 0; k < 4; k++) begin
            b4.ch_wen[k*4 +: 4]     = wen[1][k];
            b4.ch_addr[k*32 +: 32]  = addr[1][k];
            b4.ch_wdata[k*32 +: 32] = wdata[1][k];
        end
    endtask

    task automatic clear_all();
        for (int d = 0; d < 2; d++) begin
            en[d] = 4'h0;
            for (int k = 0; k < 4; k++) begin
                wen[d][k] = 4'h0; addr[d][k] = 32'h0; wdata[d][k] = 32'h0;
            end
        end
    endtask

    task automatic set_ch(input int d, input int k, input logic [3:0] w,
                          input logic [31:0] a, input logic [31:0] wd);
        en[d][k] = 1'b1; wen[d][k] = w; addr[d][k] = a; wdata[d][k] = wd;
    endtask

    // One clock: drive at negedge, compare after settling, then advance the model past the next rising edge.
    task automatic cycle(input bit do_rst);
        @(negedge clk);
        rst = do_rst;
        for (int d = 0; d < 2; d++) rdat[d] = (resp[d] >= 0) ? stub(rd_addr[d]) : $urandom();
        drive_bus();
        #1;
        for (int d = 0; d < 2; d++) begin
            int n; int g; int c;
            logic [3:0] eg, erv, og, ost, orv, ow;
            logic ose;
            logic [31:0] oa, owd;
            logic [127:0] erd, ord;
            n = (d == 0) ? 2 : 4;
            g = -1;
            if (!do_rst) begin
                for (int i = 0; i < n; i++) begin
                    c = (ptr[d] + i) % n;
                    if (g < 0 && en[d][c]) g = c;
                end
            end
            eg  = (g >= 0) ? 4'(1 << g) : 4'h0;
            erv = (!do_rst && resp[d] >= 0) ? 4'(1 << resp[d]) : 4'h0;
            erd = '0;
            for (int k = 0; k < n; k++) begin
`ifdef SRAM_ARB_RDATA_HOLD_EN
                erd[k*32 +: 32] = erv[k] ? rdat[d] : (do_rst ? 32'h0 : hold[d][k]);
`else
                erd[k*32 +: 32] = erv[k] ? rdat[d] : 32'h0;
`endif
            end
            if (d == 0) begin
                og = 4'(b2.ch_gnt); ost = 4'(b2.ch_stallreq); orv = 4'(b2.ch_rvalid);
                ose = b2.sram_en; ow = b2.sram_wen; oa = b2.sram_addr; owd = b2.sram_wdata;
                ord = 128'(b2.ch_rdata);
            end else begin
                og = b4.ch_gnt; ost = b4.ch_stallreq; orv = b4.ch_rvalid;
                ose = b4.sram_en; ow = b4.sram_wen; oa = b4.sram_addr; owd = b4.sram_wdata;
                ord = b4.ch_rdata;
            end
            check($sformatf("n%0d_gnt", n),   og,  eg);
            check($sformatf("n%0d_stall", n), ost, en[d] & ~eg);
            check($sformatf("n%0d_en", n),    ose, g >= 0);
            check($sformatf("n%0d_wen", n),   ow,  (g >= 0) ? wen[d][g] : 4'h0);
            check($sformatf("n%0d_addr", n),  oa,  (g >= 0) ? addr[d][g] : 32'h0);
            check($sformatf("n%0d_wdata", n), owd, (g >= 0) ? wdata[d][g] : 32'h0);
            check($sformatf("n%0d_rvalid", n), orv, erv);
            check($sformatf("n%0d_rdata", n), ord, erd);
            o_gnt[d] = og; o_st[d] = ost; o_rv[d] = orv; o_wen[d] = ow;
            o_addr[d] = oa; o_wdata[d] = owd; o_rdata[d] = ord;

            if (do_rst) begin
                ptr[d]  = 0;
                resp[d] = -1;
                for (int k = 0; k < 4; k++) hold[d][k] = 32'h0;
            end else begin
                if (resp[d] >= 0) hold[d][resp[d]] = rdat[d];
                if (g >= 0) begin
                    ptr[d]     = (g == n - 1) ? 0 : g + 1;
                    resp[d]    = (wen[d][g] == 4'h0) ? g : -1;
                    rd_addr[d] = addr[d][g];
                end else begin
                    resp[d] = -1;
                end
            end
            for (int k = 0; k < 4; k++) locked[d][k] = en[d][k] && (k != g);
        end
    endtask

    initial begin
        logic [31:0] r0;
        for (int d = 0; d < 2; d++) begin
            ptr[d] = 0; resp[d] = -1; rd_addr[d] = 32'h0; rdat[d] = 32'h0;
            for (int k = 0; k < 4; k++) begin
                locked[d][k] = 1'b0; hold[d][k] = 32'h0;
            end
        end
        clear_all();

        // reset with both channels requesting
        set_ch(0, 0, 4'h0, 32'h100, 32'h0);
        set_ch(0, 1, 4'h0, 32'h200, 32'h0);
        repeat (2) begin
            cycle(1'b1);
            check("rst_gnt", o_gnt[0], 4'h0);
            check("rst_stall", o_st[0], 4'b0011);
            check("rst_rvalid", o_rv[0], 4'h0);
        end

        // contention: alternate starting from ch0
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0);
            check("cont_gnt", o_gnt[0], (c % 2 == 0) ? 4'b0001 : 4'b0010);
            check("cont_addr", o_addr[0], (c % 2 == 0) ? 32'h100 : 32'h200);
            if (c > 0) check("cont_rv", o_rv[0], (c % 2 == 0) ? 4'b0010 : 4'b0001);
        end

        // lone write from ch1
        clear_all();
        set_ch(0, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF);
        cycle(1'b0);
        check("wr_wen", o_wen[0], 4'b0011);
        check("wr_wdata", o_wdata[0], 32'hDEAD_BEEF);
        check("wr_rv_last_read", o_rv[0], 4'b0010);
        clear_all();
        set_ch(0, 0, 4'h0, 32'h100, 32'h0);
        set_ch(0, 1, 4'h0, 32'h200, 32'h0);
        cycle(1'b0);
        check("wr_no_rv", o_rv[0], 4'h0);
        check("wr_ptr0", o_gnt[0], 4'b0001);

        // wrap on 4 channels: ptr to 3, then ch3 then ch0
        clear_all();
        set_ch(1, 2, 4'h0, 32'h20, 32'h0);
        cycle(1'b0);
        clear_all();
        set_ch(1, 0, 4'h0, 32'h00, 32'h0);
        set_ch(1, 3, 4'h0, 32'h30, 32'h0);
        cycle(1'b0);
        check("wrap_g3", o_gnt[1], 4'b1000);
        cycle(1'b0);
        check("wrap_g0", o_gnt[1], 4'b0001);

        // reset right after a read grant drops its response
        clear_all();
        set_ch(0, 0, 4'h0, 32'h300, 32'h0);
        cycle(1'b0);
        clear_all();
        cycle(1'b1);
        check("rstrd_rv", o_rv[0], 4'h0);
        set_ch(0, 0, 4'h0, 32'h100, 32'h0);
        set_ch(0, 1, 4'h0, 32'h200, 32'h0);
        cycle(1'b0);
        check("rstrd_ptr0", o_gnt[0], 4'b0001);
        check("rstrd_rv2", o_rv[0], 4'h0);

        // read data hold / gating
        clear_all();
        set_ch(0, 0, 4'h0, 32'h300, 32'h0);
        cycle(1'b0);
        clear_all();
        cycle(1'b0);
        r0 = o_rdata[0][31:0];
        check("hold_rv", r0, 32'h1234_5678);
        repeat (3) begin
            cycle(1'b0);
            r0 = o_rdata[0][31:0];
            check("hold_idle", r0, HOLD_EXP);
        end

        // randomized traffic with occasional reset
        for (int t = 0; t < 2000; t++) begin
            for (int d = 0; d < 2; d++) begin
                for (int k = 0; k < 4; k++) begin
                    if (k >= ((d == 0) ? 2 : 4)) begin
                        en[d][k] = 1'b0;
                    end else if (!locked[d][k]) begin
                        en[d][k]    = ($urandom_range(0, 2) != 0);
                        wen[d][k]   = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom());
                        addr[d][k]  = ($urandom_range(0, 7) == 0) ? 32'h300 : $urandom();
                        wdata[d][k] = $urandom();
                    end
                end
            end
            cycle($urandom_range(0, 39) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
